// File: rtl/er_region_ctrl.sv
// ER bounds configuration, validation and attested-run sequencer.
// Locks the bounds while armed/running and flags a complete atomic entry-to-exit run.
module er_region_ctrl #(
    parameter logic [15:0] META_BASE = 16'h0140,
    parameter logic [15:0] SMEM_BASE = 16'hA000,
    parameter logic [15:0] SMEM_SIZE = 16'h4000
) (
    input  logic        clk,
    input  logic        puc_rst,
    input  logic [15:0] pc,
    input  logic        irq,
    input  logic [15:0] data_addr,
    input  logic [15:0] data_din,
    input  logic        data_wr,
    input  logic        data_rd,
    output logic [15:0] data_dout,
    output logic [15:0] er_min,
    output logic [15:0] er_max,
    output logic        locked,
    output logic        exec_flag,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_er_min;
    logic [15:0] r_er_max;
    logic [15:0] r_prev_pc;
    logic [15:0] r_dout;
    logic        r_last_q;
    logic        r_exec_flag;
    logic        r_err;

    logic        w_sel_min, w_sel_max, w_sel_ctl;
    logic        w_wr_min, w_wr_max, w_cfg_write;
    logic        w_arm, w_clear, w_errclr;
    logic        w_unlocked, w_in_er, w_cfg_valid;
    logic        w_set_err, w_set_exec, w_clr_exec;
    logic [16:0] w_smem_end;
    logic [15:0] w_status;

    assign w_sel_min   = (data_addr == META_BASE);
    assign w_sel_max   = (data_addr == META_BASE + 16'd2);
    assign w_sel_ctl   = (data_addr == META_BASE + 16'd4);
    assign w_wr_min    = data_wr & w_sel_min;
    assign w_wr_max    = data_wr & w_sel_max;
    assign w_cfg_write = w_wr_min | w_wr_max;
    assign w_arm       = data_wr & w_sel_ctl & data_din[0];
    assign w_clear     = data_wr & w_sel_ctl & data_din[1];
    assign w_errclr    = data_wr & w_sel_ctl & data_din[2];

    assign w_unlocked  = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_in_er     = (pc >= r_er_min) && (pc <= r_er_max);
    // Secure-memory end is formed in 17 bits so a region ending at 16'hFFFF cannot wrap.
    assign w_smem_end  = {1'b0, SMEM_BASE} + {1'b0, SMEM_SIZE};
    assign w_cfg_valid = (r_er_min < r_er_max) &&
                         ((r_er_max < SMEM_BASE) || ({1'b0, r_er_min} >= w_smem_end));
    assign w_status    = {10'd0, w_cfg_valid, r_err, r_exec_flag, 1'b0, r_state};

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        w_state_nxt = r_state;
        w_set_err   = w_cfg_write & ~w_unlocked;
        w_set_exec  = 1'b0;
        w_clr_exec  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_arm) begin
                    if (w_cfg_valid) w_state_nxt = S_ARMED;
                    else             w_set_err   = 1'b1;
                end
            end
            S_ARMED: begin
                if (w_clear) begin
                    w_state_nxt = S_IDLE;
                end else if (pc == r_er_min) begin
                    w_state_nxt = S_RUN;
                end else if ((pc > r_er_min) && (pc <= r_er_max)) begin
                    w_state_nxt = S_IDLE;
                    w_set_err   = 1'b1;
                end
            end
            S_RUN: begin
                if (w_clear) begin
                    w_state_nxt = S_IDLE;
                end else if (irq) begin
                    w_state_nxt = S_IDLE;
                    w_set_err   = 1'b1;
                end else if (!w_in_er && r_last_q) begin
                    w_state_nxt = S_DONE;
                    w_set_exec  = 1'b1;
                end else if (!w_in_er || ((pc == r_er_min) && (pc != r_prev_pc))) begin
                    w_state_nxt = S_IDLE;
                    w_set_err   = 1'b1;
                end
            end
            S_DONE: begin
                if (w_cfg_write) begin
                    w_state_nxt = S_IDLE;
                    w_clr_exec  = 1'b1;
                end else if (w_arm) begin
                    w_clr_exec = 1'b1;
                    if (w_cfg_valid) begin
                        w_state_nxt = S_ARMED;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_set_err   = 1'b1;
                    end
                end else if (pc == r_er_min) begin
                    w_state_nxt = S_RUN;
                    w_clr_exec  = 1'b1;
                end else if (w_in_er) begin
                    w_state_nxt = S_IDLE;
                    w_clr_exec  = 1'b1;
                    w_set_err   = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge puc_rst) begin
        if (puc_rst) begin
            r_state     <= S_IDLE;
            r_er_min    <= 16'd0;
            r_er_max    <= 16'd0;
            r_prev_pc   <= 16'd0;
            r_dout      <= 16'd0;
            r_last_q    <= 1'b0;
            r_exec_flag <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_prev_pc <= pc;
            r_last_q  <= (pc == r_er_max);
            if (w_wr_min && w_unlocked) r_er_min <= data_din;
            if (w_wr_max && w_unlocked) r_er_max <= data_din;
            if (w_set_exec)      r_exec_flag <= 1'b1;
            else if (w_clr_exec) r_exec_flag <= 1'b0;
            r_err <= w_set_err | (r_err & ~w_errclr);
            // Zero when idle so the read port can be OR-combined onto the bus.
            if (data_rd && w_sel_min)      r_dout <= r_er_min;
            else if (data_rd && w_sel_max) r_dout <= r_er_max;
            else if (data_rd && w_sel_ctl) r_dout <= w_status;
            else                           r_dout <= 16'd0;
        end
    end

    assign data_dout = r_dout;
    assign er_min    = r_er_min;
    assign er_max    = r_er_max;
    assign locked    = (r_state == S_ARMED) || (r_state == S_RUN);
    assign exec_flag = r_exec_flag;
    assign err       = r_err;

endmodule

// File: tb/tb_er_region_ctrl.sv
// Directed and randomized bench for er_region_ctrl against a rule-level reference model.
module tb_er_region_ctrl;

    localparam logic [15:0] A_MIN = 16'h0140;
    localparam logic [15:0] A_MAX = 16'h0142;
    localparam logic [15:0] A_CTL = 16'h0144;
    localparam logic [1:0]  ST_IDLE = 2'd0, ST_ARMED = 2'd1, ST_RUN = 2'd2, ST_DONE = 2'd3;

    logic        clk = 1'b0;
    logic        puc_rst;
    logic [15:0] pc;
    logic        irq;
    logic [15:0] data_addr;
    logic [15:0] data_din;
    logic        data_wr;
    logic        data_rd;
    logic [15:0] data_dout;
    logic [15:0] er_min;
    logic [15:0] er_max;
    logic        locked;
    logic        exec_flag;
    logic        err;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [1:0]  m_state;
    logic [15:0] m_min, m_max, m_dout;
    logic        m_exec, m_err;
    logic [15:0] m_hist[$];

    er_region_ctrl dut (
        .clk       (clk),
        .puc_rst   (puc_rst),
        .pc        (pc),
        .irq       (irq),
        .data_addr (data_addr),
        .data_din  (data_din),
        .data_wr   (data_wr),
        .data_rd   (data_rd),
        .data_dout (data_dout),
        .er_min    (er_min),
        .er_max    (er_max),
        .locked    (locked),
        .exec_flag (exec_flag),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit model_valid();
        return (int'(m_min) < int'(m_max)) &&
               ((int'(m_max) < 'hA000) || (int'(m_min) >= 'hA000 + 'h4000));
    endfunction

    task automatic model_reset();
        m_state = ST_IDLE;
        m_min = 16'd0; m_max = 16'd0; m_dout = 16'd0;
        m_exec = 1'b0; m_err = 1'b0;
        m_hist.delete();
    endtask

    // Applies the controller's rules to the inputs present just before the next edge.
    task automatic model_edge();
        logic [1:0]  ns;
        logic [15:0] rd;
        bit wmin, wmax, arm, clr, eclr, in_er, cfg_open, valid, last, reentry, viol, set_x, clr_x;
        wmin     = data_wr && data_addr == A_MIN;
        wmax     = data_wr && data_addr == A_MAX;
        arm      = data_wr && data_addr == A_CTL && data_din[0];
        clr      = data_wr && data_addr == A_CTL && data_din[1];
        eclr     = data_wr && data_addr == A_CTL && data_din[2];
        in_er    = pc >= m_min && pc <= m_max;
        cfg_open = m_state == ST_IDLE || m_state == ST_DONE;
        valid    = model_valid();
        last     = m_hist.size() > 0 && m_hist[$] == m_max;
        reentry  = pc == m_min && (m_hist.size() == 0 || m_hist[$] != pc);
        ns = m_state; viol = (wmin || wmax) && !cfg_open; set_x = 0; clr_x = 0;
        if (m_state == ST_IDLE) begin
            if (arm && valid) ns = ST_ARMED;
            else if (arm)     viol = 1;
        end else if (m_state == ST_ARMED) begin
            if (clr)                            ns = ST_IDLE;
            else if (pc == m_min)               ns = ST_RUN;
            else if (pc > m_min && pc <= m_max) begin ns = ST_IDLE; viol = 1; end
        end else if (m_state == ST_RUN) begin
            if (clr)                 ns = ST_IDLE;
            else if (irq)            begin ns = ST_IDLE; viol = 1; end
            else if (!in_er && last) begin ns = ST_DONE; set_x = 1; end
            else if (!in_er)         begin ns = ST_IDLE; viol = 1; end
            else if (reentry)        begin ns = ST_IDLE; viol = 1; end
        end else begin
            if (wmin || wmax)      begin ns = ST_IDLE; clr_x = 1; end
            else if (arm && valid) begin ns = ST_ARMED; clr_x = 1; end
            else if (arm)          begin ns = ST_IDLE; clr_x = 1; viol = 1; end
            else if (pc == m_min)  begin ns = ST_RUN; clr_x = 1; end
            else if (in_er)        begin ns = ST_IDLE; clr_x = 1; viol = 1; end
        end
        rd = 16'd0;
        if (data_rd && data_addr == A_MIN) rd = m_min;
        if (data_rd && data_addr == A_MAX) rd = m_max;
        if (data_rd && data_addr == A_CTL) rd = {10'd0, valid, m_err, m_exec, 1'b0, m_state};
        m_dout = rd;
        m_hist.push_back(pc);
        if (m_hist.size() > 4) void'(m_hist.pop_front());
        if (cfg_open && wmin) m_min = data_din;
        if (cfg_open && wmax) m_max = data_din;
        if (set_x) m_exec = 1'b1; else if (clr_x) m_exec = 1'b0;
        if (viol) m_err = 1'b1; else if (eclr) m_err = 1'b0;
        m_state = ns;
    endtask

    task automatic compare_all();
        check("er_min", er_min, m_min);
        check("er_max", er_max, m_max);
        check("data_dout", data_dout, m_dout);
        check("locked", 16'(locked), 16'(m_state == ST_ARMED || m_state == ST_RUN));
        check("exec_flag", 16'(exec_flag), 16'(m_exec));
        check("err", 16'(err), 16'(m_err));
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
        data_wr = 1'b0;
        data_rd = 1'b0;
        irq     = 1'b0;
    endtask

    task automatic bus_wr(input logic [15:0] addr, input logic [15:0] din);
        data_addr = addr; data_din = din; data_wr = 1'b1;
        tick();
    endtask

    task automatic bus_rd(input logic [15:0] addr);
        data_addr = addr; data_rd = 1'b1;
        tick();
    endtask

    task automatic walk(input logic [15:0] from, input logic [15:0] to);
        for (int a = int'(from); a <= int'(to); a += 2) begin
            pc = 16'(a);
            tick();
        end
    endtask

    initial begin
        puc_rst = 1'b1; pc = 16'd0; irq = 1'b0;
        data_addr = 16'd0; data_din = 16'd0; data_wr = 1'b0; data_rd = 1'b0;
        model_reset();
        #12 puc_rst = 1'b0;
        check("reset_er_min", er_min, 16'h0000);
        check("reset_er_max", er_max, 16'h0000);
        check("reset_flags", {13'd0, locked, exec_flag, err}, 16'h0000);
        bus_rd(A_CTL);
        check("reset_status", data_dout, 16'h0000);

        // Complete atomic run
        pc = 16'h0100;
        bus_wr(A_MIN, 16'hE000);
        bus_wr(A_MAX, 16'hE010);
        bus_wr(A_CTL, 16'h0001);
        bus_rd(A_CTL);
        check("armed_status", data_dout, 16'h0021);
        pc = 16'hE000; tick();
        check("run_locked", 16'(locked), 16'h0001);
        walk(16'hE002, 16'hE010);
        pc = 16'hF000; tick();
        check("done_exec", 16'(exec_flag), 16'h0001);
        check("done_unlocked", 16'(locked), 16'h0000);
        bus_rd(A_CTL);
        check("done_status", data_dout, 16'h002B);

        // Interrupt mid-run, with ERRCLR in the same cycle: the violation wins
        bus_wr(A_CTL, 16'h0001);
        pc = 16'hE000; tick();
        pc = 16'hE002; tick();
        pc = 16'hE004; irq = 1'b1;
        bus_wr(A_CTL, 16'h0004);
        check("irq_err", 16'(err), 16'h0001);
        check("irq_exec", 16'(exec_flag), 16'h0000);
        check("irq_unlocked", 16'(locked), 16'h0000);
        pc = 16'h0100;
        bus_wr(A_CTL, 16'h0004);
        check("errclr", 16'(err), 16'h0000);

        // Locked write dropped; write at exit also dropped; run still completes
        bus_wr(A_CTL, 16'h0001);
        pc = 16'hE000; tick();
        pc = 16'hE002;
        bus_wr(A_MAX, 16'h1234);
        check("locked_wr_max", er_max, 16'hE010);
        check("locked_wr_err", 16'(err), 16'h0001);
        walk(16'hE004, 16'hE010);
        pc = 16'hF000;
        bus_wr(A_MIN, 16'h5000);
        check("exit_wr_min", er_min, 16'hE000);
        check("exit_done", 16'(exec_flag), 16'h0001);

        // Write in DONE returns to IDLE; jump into the middle while ARMED
        bus_wr(A_CTL, 16'h0004);
        bus_wr(A_MIN, 16'hE000);
        check("done_wr_exec", 16'(exec_flag), 16'h0000);
        bus_rd(A_CTL);
        check("done_wr_status", data_dout, 16'h0020);
        bus_wr(A_CTL, 16'h0001);
        pc = 16'hE008; tick();
        check("armed_jump_err", 16'(err), 16'h0001);
        check("armed_jump_state", 16'(locked), 16'h0000);
        pc = 16'h0100;
        bus_wr(A_CTL, 16'h0004);

        // Re-entry jump to er_min during RUN
        bus_wr(A_CTL, 16'h0001);
        pc = 16'hE000; tick();
        pc = 16'hE002; tick();
        pc = 16'hE000; tick();
        check("reentry_err", 16'(err), 16'h0001);
        pc = 16'h0100;
        bus_wr(A_CTL, 16'h0004);

        // Region overlapping secure memory cannot be armed
        bus_wr(A_MIN, 16'hA100);
        bus_wr(A_MAX, 16'hA200);
        bus_wr(A_CTL, 16'h0001);
        bus_rd(A_CTL);
        check("smem_status", data_dout, 16'h0010);
        bus_wr(A_CTL, 16'h0004);

        // Asynchronous reset mid-run
        bus_wr(A_MIN, 16'hE000);
        bus_wr(A_MAX, 16'hE010);
        bus_wr(A_CTL, 16'h0001);
        pc = 16'hE000; tick();
        pc = 16'hE002; tick();
        #2 puc_rst = 1'b1;
        #1;
        check("async_rst_locked", 16'(locked), 16'h0000);
        check("async_rst_exec", 16'(exec_flag), 16'h0000);
        check("async_rst_min", er_min, 16'h0000);
        model_reset();
        @(negedge clk);
        puc_rst = 1'b0;

        // Randomized traffic against the model
        pc = 16'h0000;
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 5)       pc = pc + 16'd2;
            else if (r == 5) pc = m_min;
            else if (r == 6) pc = m_max;
            else if (r == 7) pc = m_max + 16'd2;
            else if (r == 8) pc = 16'($urandom);
            irq = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 5) == 0) begin
                r = int'($urandom_range(0, 5));
                if (r == 0) begin
                    data_addr = A_MIN; data_wr = 1'b1;
                    case ($urandom_range(0, 3))
                        0:       data_din = 16'hE000 + 16'(2 * $urandom_range(0, 8));
                        1:       data_din = 16'h1000;
                        2:       data_din = 16'hA100;
                        default: data_din = 16'($urandom);
                    endcase
                end else if (r == 1) begin
                    data_addr = A_MAX; data_wr = 1'b1;
                    if ($urandom_range(0, 3) == 0) data_din = 16'($urandom);
                    else data_din = m_min + 16'(2 * $urandom_range(1, 12));
                end else if (r == 2 && (m_state == ST_IDLE || m_state == ST_DONE)) begin
                    data_addr = A_CTL; data_wr = 1'b1; data_din = {13'($urandom), 3'b001};
                end else if (r == 3 && (m_state == ST_ARMED || m_state == ST_RUN)) begin
                    data_addr = A_CTL; data_wr = 1'b1; data_din = {13'($urandom), 3'b010};
                end else if (r == 4) begin
                    data_addr = A_CTL; data_wr = 1'b1; data_din = {13'($urandom), 3'b100};
                end else begin
                    data_addr = A_MIN + 16'(2 * $urandom_range(0, 3)); data_rd = 1'b1;
                end
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
